// File: rtl/board_ram_wsched.sv
// Board RAM write scheduler: round-robin arbitration of two requesters plus a
// preemptible bulk-fill engine, compiled in when BOARD_WSCHED_CLEAR_EN is defined.
module board_ram_wsched #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              CLK_PLL,
  input  logic              RST_N,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_b,
  input  logic              clr_start,
  input  logic [ADDR_W-1:0] clr_base,
  input  logic [ADDR_W:0]   clr_len,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_data
);

  logic              elig_a, elig_b, gnt_a, gnt_b;
  logic              prio_b_q;
  logic              fill_go;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;

  // A requester whose ack is showing is still holding its old request.
  assign elig_a = req_a & ~ack_a;
  assign elig_b = req_b & ~ack_b;
  assign gnt_a  = elig_a & (~elig_b | ~prio_b_q);
  assign gnt_b  = elig_b & (~elig_a |  prio_b_q);

`ifdef BOARD_WSCHED_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_eff, rem_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] dat_q;
  logic              start_ok, done_d, done_q;

  assign len_eff  = (clr_len > LEN_MAX) ? LEN_MAX : clr_len;
  assign start_ok = (state_q == S_IDLE) && clr_start && (len_eff != '0);

  always_ff @(posedge CLK_PLL or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok)      state_d = S_CLEAR;
      S_CLEAR: if (rem_q == '0)   state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // The first fill write can issue on the very edge that accepts clr_start,
  // so the fill source is the command inputs while still idle.
  always_comb begin
    clr_busy  = (state_q == S_CLEAR);
    fill_go   = ~(elig_a | elig_b) &
                (start_ok | ((state_q == S_CLEAR) && (rem_q != '0)));
    fill_addr = (state_q == S_CLEAR) ? ptr_q : clr_base;
    fill_data = (state_q == S_CLEAR) ? dat_q : clr_data;
    done_d    = ((state_q == S_IDLE) && clr_start && (len_eff == '0)) ||
                ((state_q == S_CLEAR) && (rem_q == '0));
  end

  always_ff @(posedge CLK_PLL or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q  <= '0;
      rem_q  <= '0;
      dat_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (start_ok) begin
        ptr_q <= clr_base + ADDR_W'(fill_go);
        rem_q <= len_eff - (ADDR_W+1)'(fill_go);
        dat_q <= clr_data;
      end else if (fill_go) begin
        ptr_q <= ptr_q + 1'b1;
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  assign clr_done = done_q;
`else
  // Fill engine absent: the FSM never leaves IDLE.
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_base, clr_len, clr_data};
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign fill_go    = 1'b0;
  assign fill_addr  = '0;
  assign fill_data  = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge CLK_PLL or negedge RST_N) begin
    if (!RST_N) begin
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_data  <= '0;
      prio_b_q  <= 1'b0;
    end else begin
      ack_a   <= gnt_a;
      ack_b   <= gnt_b;
      ram_wen <= gnt_a | gnt_b | fill_go;
      if (gnt_a) begin
        ram_waddr <= addr_a;
        ram_data  <= data_a;
        prio_b_q  <= 1'b1;
      end else if (gnt_b) begin
        ram_waddr <= addr_b;
        ram_data  <= data_b;
        prio_b_q  <= 1'b0;
      end else if (fill_go) begin
        ram_waddr <= fill_addr;
        ram_data  <= fill_data;
      end
    end
  end

endmodule
